pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Program-counter and instruction-fetch stage of the 8-bit core. It holds the PC and fetches one instruction at a time from instruction memory over a req/ack handshake, then presents that instruction to decode. When decode consumes the instruction, the block applies the 2-bit next-PC select from the branch-decision unit (00 sequential, 01 branch, 10 jump).

Parameters:
PC_W, 8, PC and address width
INSTR_W, 8, instruction width
RESET_PC, 8'h00, PC value loaded on reset
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
pc_sel  in  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 illegal; sampled only on consume
branch_off  in  PC_W  sign-extended branch offset
jump_addr  in  PC_W  absolute jump target
stall  in  1  decode not ready; holds the presented instruction
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address, always equal to pc
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  INSTR_W  fetched instruction
instr  out  INSTR_W  instruction presented to decode
instr_pc  out  PC_W  address of instr
instr_valid  out  1  instr/instr_pc valid
pc  out  PC_W  current PC register
retired  out  CNT_W  count of consumed instructions
sel_err  out  1  sticky flag: pc_sel=11 seen on consume

Behaviour:
- States: BOOT, FETCH, ISSUE. rst_n=0 forces BOOT asynchronously.
- Reset values: pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, imem_req=0, retired=0, sel_err=0.
- BOOT: imem_req=0. Always moves to FETCH on the next edge, so the first request comes one cycle after reset release.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until ack.
  - On imem_ack: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, go to ISSUE.
  - Ack in the first request cycle is legal, giving 1-cycle fetch latency (ack at edge N, instr_valid high after N).
- ISSUE:
  - imem_req=0; instr, instr_pc and instr_valid are held.
  - A consume occurs on a cycle with instr_valid=1 and stall=0.
  - On consume: pc<=next_pc, instr_valid<=0, retired<=retired+1 (wraps mod 2^CNT_W), go to FETCH.
  - The new request is visible the cycle after consume.
- next_pc is computed from instr_pc, modulo 2^PC_W with silent wrap:
  - 00: instr_pc+1
  - 01: instr_pc+1+branch_off (two's complement)
  - 10: jump_addr
  - 11: treated as 00, and sel_err<=1 (sticky until reset)
- pc_sel, branch_off and jump_addr are ignored when no consume occurs.
- imem_ack outside FETCH is ignored. stall outside ISSUE is ignored.
- Reset mid-operation (any state): outputs return to reset values immediately. An in-flight fetch is abandoned and a late ack is ignored because the block is in BOOT.
- At most one instruction is outstanding. No prefetch, no flush needed.

Decomposition:
- Shared package: state encoding (BOOT/FETCH/ISSUE); PC_SEL_SEQ=2'b00, PC_SEL_BR=2'b01, PC_SEL_JMP=2'b10, PC_SEL_ILL=2'b11. The branch-decision unit uses the same PC_SEL constants.
- One combinational sub-module, next_pc_calc, with inputs instr_pc, pc_sel, branch_off, jump_addr and outputs next_pc and illegal. All state lives in pc_fetch_unit.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release -> one cycle with imem_req=0, then imem_req=1, imem_addr=8'h00; all outputs at reset values during reset.
- Sequential fetch: ack same cycle with rdata=8'h5A, stall=0, pc_sel=00 -> instr=8'h5A, instr_pc=8'h00, next request addr 8'h01, retired=1.
- Branch: instr_pc=8'h10, pc_sel=01, branch_off=8'hFC -> next imem_addr=8'h0D. Jump: pc_sel=10, jump_addr=8'hA0 -> next addr 8'hA0.
- Stall and wrap: stall=1 for 3 cycles in ISSUE -> instr/instr_pc stable, no request, retired unchanged. Then instr_pc=8'hFF with pc_sel=00 -> next addr 8'h00.
- Illegal select: pc_sel=11 at consume of instr_pc=8'h20 -> next addr 8'h21, sel_err=1 and it remains 1 through subsequent fetches.
- Reset mid-fetch: assert rst_n=0 while imem_req=1 awaiting ack -> imem_req drops without waiting for a clock edge. An ack arriving in the following BOOT cycle is ignored; the next fetch is at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and next-PC select codes.
// The branch-decision unit drives pc_sel using the same PC_SEL_* constants.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } fetch_state_e;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;
  localparam logic [1:0] PC_SEL_ILL = 2'b11;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and instruction memory (slave).
interface pc_fetch_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
);

  logic               req;
  logic [PC_W-1:0]    addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection from the address of the instruction being consumed.
// All arithmetic wraps modulo 2^PC_W.
module next_pc_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0]        instr_pc,
  input  logic [1:0]             pc_sel,
  input  logic signed [PC_W-1:0] branch_off,
  input  logic [PC_W-1:0]        jump_addr,
  output logic [PC_W-1:0]        next_pc,
  output logic                   illegal
);

  always_comb begin
    next_pc = instr_pc + PC_W'(1);
    illegal = 1'b0;
    case (pc_sel)
      PC_SEL_BR:  next_pc = instr_pc + PC_W'(1) + $unsigned(branch_off);
      PC_SEL_JMP: next_pc = jump_addr;
      // Illegal select falls back to sequential so the core keeps running.
      PC_SEL_ILL: illegal = 1'b1;
      default:    next_pc = instr_pc + PC_W'(1);
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch: BOOT -> FETCH (req/ack) -> ISSUE (wait for decode).
// On consume the next PC comes from next_pc_calc and the retired counter advances.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 8,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00,
  parameter int              CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             pc_sel,
  input  logic signed [PC_W-1:0] branch_off,
  input  logic [PC_W-1:0]        jump_addr,
  input  logic                   stall,
  pc_fetch_unit_if.master        imem,
  output logic [INSTR_W-1:0]     instr,
  output logic [PC_W-1:0]        instr_pc,
  output logic                   instr_valid,
  output logic [PC_W-1:0]        pc,
  output logic [CNT_W-1:0]       retired,
  output logic                   sel_err
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               sel_err_q, sel_err_d;
  logic [PC_W-1:0]    next_pc;
  logic               sel_illegal;

  next_pc_calc #(.PC_W(PC_W)) u_next_pc (
    .instr_pc   (instr_pc_q),
    .pc_sel     (pc_sel),
    .branch_off (branch_off),
    .jump_addr  (jump_addr),
    .next_pc    (next_pc),
    .illegal    (sel_illegal)
  );

  // Request is decoded from state so an async reset drops it without waiting for an edge.
  assign imem.req    = (state_q == ST_FETCH);
  assign imem.addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign retired     = retired_q;
  assign sel_err     = sel_err_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    retired_d  = retired_q;
    sel_err_d  = sel_err_q;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem.ack) begin
          instr_d    = imem.rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (valid_q && !stall) begin
          pc_d      = next_pc;
          valid_d   = 1'b0;
          retired_d = retired_q + CNT_W'(1);
          sel_err_d = sel_err_q | sel_illegal;
          state_d   = ST_FETCH;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      retired_q  <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      retired_q  <= retired_d;
      sel_err_q  <= sel_err_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, sequential/branch/jump/wrap, stall, illegal select, reset mid-fetch.
module tb_pc_fetch_unit;

  logic              clk;
  logic              rst_n;
  logic [1:0]        pc_sel;
  logic [7:0]        branch_off;
  logic [7:0]        jump_addr;
  logic              stall;
  logic [7:0]        instr;
  logic [7:0]        instr_pc;
  logic              instr_valid;
  logic [7:0]        pc;
  logic [15:0]       retired;
  logic              sel_err;

  int n_cmp;
  int n_err;

  pc_fetch_unit_if #(.PC_W(8), .INSTR_W(8)) imem_bus ();

  pc_fetch_unit #(
    .PC_W(8), .INSTR_W(8), .RESET_PC(8'h00), .CNT_W(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_sel      (pc_sel),
    .branch_off  (branch_off),
    .jump_addr   (jump_addr),
    .stall       (stall),
    .imem        (imem_bus.master),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .pc          (pc),
    .retired     (retired),
    .sel_err     (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [7:0] d);
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = d;
    step();
    imem_bus.ack   = 1'b0;
  endtask

  task automatic consume(input logic [1:0] sel, input logic [7:0] off, input logic [7:0] jmp);
    pc_sel     = sel;
    branch_off = off;
    jump_addr  = jmp;
    stall      = 1'b0;
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    pc_sel = 2'b00;
    branch_off = 8'h00;
    jump_addr = 8'h00;
    stall = 1'b0;
    imem_bus.ack = 1'b0;
    imem_bus.rdata = 8'h00;

    // Reset held for three cycles
    step(); step(); step();
    chk("rst_req",     16'(imem_bus.req), 16'h0);
    chk("rst_pc",      16'(pc),           16'h00);
    chk("rst_instr",   16'(instr),        16'h00);
    chk("rst_ipc",     16'(instr_pc),     16'h00);
    chk("rst_valid",   16'(instr_valid),  16'h0);
    chk("rst_retired", retired,           16'h0);
    chk("rst_selerr",  16'(sel_err),      16'h0);

    rst_n = 1'b1;
    chk("boot_req", 16'(imem_bus.req), 16'h0);
    step();
    chk("first_req",  16'(imem_bus.req),  16'h1);
    chk("first_addr", 16'(imem_bus.addr), 16'h00);

    // Sequential fetch with 1-cycle ack
    fetch(8'h5A);
    chk("seq_instr", 16'(instr),         16'h5A);
    chk("seq_ipc",   16'(instr_pc),      16'h00);
    chk("seq_valid", 16'(instr_valid),   16'h1);
    chk("seq_noreq", 16'(imem_bus.req),  16'h0);
    consume(2'b00, 8'h00, 8'h00);
    chk("seq_req",     16'(imem_bus.req),  16'h1);
    chk("seq_addr",    16'(imem_bus.addr), 16'h01);
    chk("seq_validlo", 16'(instr_valid),   16'h0);
    chk("seq_retired", retired,            16'h1);

    // Jump to 0x10, then branch back by 4
    fetch(8'h11);
    consume(2'b10, 8'h00, 8'h10);
    chk("jmp10_addr", 16'(imem_bus.addr), 16'h10);
    fetch(8'h22);
    chk("br_ipc", 16'(instr_pc), 16'h10);
    consume(2'b01, 8'hFC, 8'h99);
    chk("br_addr", 16'(imem_bus.addr), 16'h0D);
    fetch(8'h33);
    consume(2'b10, 8'h00, 8'hA0);
    chk("jmpA0_addr", 16'(imem_bus.addr), 16'hA0);

    // Stall for three cycles; ack and select inputs must be ignored meanwhile
    fetch(8'hC3);
    stall = 1'b1;
    pc_sel = 2'b10;
    jump_addr = 8'h55;
    imem_bus.ack = 1'b1;
    imem_bus.rdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr",   16'(instr),         16'hC3);
      chk("stall_ipc",     16'(instr_pc),      16'hA0);
      chk("stall_req",     16'(imem_bus.req),  16'h0);
      chk("stall_retired", retired,            16'h4);
    end
    imem_bus.ack = 1'b0;
    chk("stall_pc", 16'(pc), 16'hA0);
    consume(2'b10, 8'h00, 8'hFF);
    chk("jmpFF_addr", 16'(imem_bus.addr), 16'hFF);
    chk("jmpFF_ret",  retired,            16'h5);

    // Sequential wrap from 0xFF
    fetch(8'h44);
    consume(2'b00, 8'h00, 8'h00);
    chk("wrap_addr", 16'(imem_bus.addr), 16'h00);

    // Illegal select at 0x20
    fetch(8'h55);
    consume(2'b10, 8'h00, 8'h20);
    fetch(8'h66);
    consume(2'b11, 8'h05, 8'h77);
    chk("ill_addr",   16'(imem_bus.addr), 16'h21);
    chk("ill_selerr", 16'(sel_err),       16'h1);
    chk("ill_ret",    retired,            16'h8);

    // Delayed ack: request and address held stable
    step();
    chk("wait_req",  16'(imem_bus.req),  16'h1);
    chk("wait_addr", 16'(imem_bus.addr), 16'h21);
    step();
    chk("wait_addr2", 16'(imem_bus.addr), 16'h21);
    fetch(8'h77);
    chk("late_instr", 16'(instr),    16'h77);
    chk("late_ipc",   16'(instr_pc), 16'h21);
    consume(2'b00, 8'h00, 8'h00);
    chk("sticky_selerr", 16'(sel_err),       16'h1);
    chk("after_ill_addr", 16'(imem_bus.addr), 16'h22);

    // Asynchronous reset while a request is outstanding
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req",     16'(imem_bus.req), 16'h0);
    chk("arst_pc",      16'(pc),           16'h00);
    chk("arst_retired", retired,           16'h0);
    chk("arst_selerr",  16'(sel_err),      16'h0);
    chk("arst_instr",   16'(instr),        16'h00);
    step();
    rst_n = 1'b1;
    imem_bus.ack = 1'b1;
    imem_bus.rdata = 8'h99;
    step();
    imem_bus.ack = 1'b0;
    chk("post_req",   16'(imem_bus.req),  16'h1);
    chk("post_addr",  16'(imem_bus.addr), 16'h00);
    chk("post_valid", 16'(instr_valid),   16'h0);
    chk("post_instr", 16'(instr),         16'h00);
    fetch(8'h3C);
    chk("post_fetch_instr", 16'(instr),       16'h3C);
    chk("post_fetch_valid", 16'(instr_valid), 16'h1);
    chk("post_fetch_ipc",   16'(instr_pc),    16'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
